// File: rtl/ldpe_bank_pkg.sv
// ldpe_bank_pkg: channel FSM state type and hold-counter sizing shared by the latch bank.
package ldpe_bank_pkg;
    typedef enum logic [1:0] {CLOSED, OPEN, HOLD} state_t;
    function automatic int cnt_w(input int hold_cyc);
        return (hold_cyc < 1) ? 1 : $clog2(hold_cyc + 1);
    endfunction
endpackage

// File: rtl/ldpe_bank_chan.sv
// ldpe_bank_chan: one clocked LDPE-style latch channel (FSM, hold counter, data register, VIOL flag).
// VIOL flag register is built only when LDPE_BANK_VIOL_EN is defined.
module ldpe_bank_chan
    import ldpe_bank_pkg::*;
#(
    parameter int W = 8,
    parameter logic [W-1:0] INIT = '0,
    parameter int HOLD_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         g,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         open,
    output logic         viol
);
    localparam int CW = cnt_w(HOLD_CYC);
    state_t state = CLOSED;
    state_t nxt;
    logic [CW-1:0] cnt = '0;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0] q_r = INIT;
    logic load;
    always_comb begin
        nxt = state;
        cnt_nxt = cnt;
        load = 1'b0;
        case (state)
            CLOSED: begin
                nxt = g ? OPEN : CLOSED;
                load = g;
            end
            OPEN: begin
                load = g;
                if (!g) begin
                    nxt = (HOLD_CYC == 0) ? CLOSED : HOLD;
                    cnt_nxt = CW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                nxt = (cnt == '0) ? CLOSED : HOLD;
                cnt_nxt = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            default: nxt = CLOSED;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLOSED;
            cnt <= '0;
            q_r <= '1;
        end else begin
            state <= nxt;
            cnt <= cnt_nxt;
            if (load) q_r <= d;
        end
    end
    assign q = q_r;
    assign open = (state == OPEN);
`ifdef LDPE_BANK_VIOL_EN
    // sticky until reset: any gate request seen while the hold window is running
    logic viol_r = 1'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) viol_r <= 1'b0;
        else if (state == HOLD && g) viol_r <= 1'b1;
    end
    assign viol = viol_r;
`else
    assign viol = 1'b0;
`endif
endmodule

// File: rtl/ldpe_bank.sv
// ldpe_bank: bank of CH independent clocked LDPE emulations sharing clock, preset and global gate.
// Optional sticky violation flags enabled by LDPE_BANK_VIOL_EN.
module ldpe_bank #(
    parameter int CH = 4,
    parameter int W = 8,
    parameter logic [CH*W-1:0] INIT = '0,
    parameter int HOLD_CYC = 2
) (
    input  logic            C,
    input  logic            PRE,
    input  logic            GE,
    input  logic [CH-1:0]   G,
    input  logic [CH*W-1:0] D,
    output logic [CH*W-1:0] Q,
    output logic [CH-1:0]   OPEN,
    output logic [CH-1:0]   VIOL
);
    for (genvar i = 0; i < CH; i++) begin : g_chan
        ldpe_bank_chan #(
            .W(W),
            .INIT(INIT[i*W +: W]),
            .HOLD_CYC(HOLD_CYC)
        ) u_chan (
            .clk(C),
            .rst(PRE),
            .g(G[i] & GE),
            .d(D[i*W +: W]),
            .q(Q[i*W +: W]),
            .open(OPEN[i]),
            .viol(VIOL[i])
        );
    end
endmodule

// File: tb/tb_ldpe_bank.sv
// tb_ldpe_bank: directed scoreboard bench for ldpe_bank (HOLD_CYC=2 bank plus HOLD_CYC=0 single channel).
module tb_ldpe_bank;
`ifdef LDPE_BANK_VIOL_EN
    localparam logic VE = 1'b1;
`else
    localparam logic VE = 1'b0;
`endif
    typedef struct {
        string       tag;
        logic [31:0] q;
        logic [3:0]  o;
        logic [3:0]  v;
        logic [7:0]  qb;
        logic        ob;
    } exp_t;

    logic C = 1'b0;
    logic PRE, GE, ge_b, g_b, open_b, viol_b;
    logic [3:0] G, OPEN, VIOL;
    logic [31:0] D, Q;
    logic [7:0] d_b, q_b;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    ldpe_bank #(.CH(4), .W(8), .INIT(32'h112233A5), .HOLD_CYC(2)) dut (
        .C(C), .PRE(PRE), .GE(GE), .G(G), .D(D), .Q(Q), .OPEN(OPEN), .VIOL(VIOL)
    );
    ldpe_bank #(.CH(1), .W(8), .INIT(8'h5A), .HOLD_CYC(0)) dut0 (
        .C(C), .PRE(PRE), .GE(ge_b), .G(g_b), .D(d_b), .Q(q_b), .OPEN(open_b), .VIOL(viol_b)
    );

    always #5 C = ~C;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] q, input logic [3:0] o,
                        input logic [3:0] v, input logic [7:0] qb, input logic ob);
        sb.push_back('{tag, q, o, VE ? v : 4'h0, qb, ob});
    endtask

    task automatic compare();
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".Q"}, Q, e.q);
            chk({e.tag, ".OPEN"}, {28'h0, OPEN}, {28'h0, e.o});
            chk({e.tag, ".VIOL"}, {28'h0, VIOL}, {28'h0, e.v});
            chk({e.tag, ".Q0"}, {24'h0, q_b}, {24'h0, e.qb});
            chk({e.tag, ".OPEN0"}, {31'h0, open_b}, {31'h0, e.ob});
            chk({e.tag, ".VIOL0"}, {31'h0, viol_b}, 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
        compare();
    endtask

    initial begin
        PRE = 1'b0; GE = 1'b0; G = 4'h0; D = 32'h0;
        ge_b = 1'b1; g_b = 1'b0; d_b = 8'h0;
        #1;
        push("powerup", 32'h112233A5, 4'h0, 4'h0, 8'h5A, 1'b0);
        compare();
        // 1 ns preset pulse between clock edges
        PRE = 1'b1;
        #1;
        PRE = 1'b0;
        #1;
        push("pre_pulse", 32'hFFFFFFFF, 4'h0, 4'h0, 8'hFF, 1'b0);
        compare();
        G = 4'b0001; GE = 1'b1; D = 32'h4433223C;
        push("open_ch0", 32'hFFFFFF3C, 4'h1, 4'h0, 8'hFF, 1'b0);
        tick();
        G = 4'b0010; D = 32'h4433553C;
        push("open_ch1", 32'hFFFF553C, 4'h2, 4'h0, 8'hFF, 1'b0);
        tick();
        G = 4'b0000; D = 32'h44336677;
        push("drop_ch1", 32'hFFFF553C, 4'h0, 4'h0, 8'hFF, 1'b0);
        tick();
        G = 4'b0010; D = 32'h44338877;
        push("hold1", 32'hFFFF553C, 4'h0, 4'h2, 8'hFF, 1'b0);
        tick();
        D = 32'h44338977;
        push("hold2", 32'hFFFF553C, 4'h0, 4'h2, 8'hFF, 1'b0);
        tick();
        D = 32'h44339977;
        push("reopen", 32'hFFFF993C, 4'h2, 4'h2, 8'hFF, 1'b0);
        tick();
        G = 4'b1111; D = 32'hA4A3A2A1;
        push("all_open", 32'hA4A3A2A1, 4'hF, 4'h2, 8'hFF, 1'b0);
        tick();
        GE = 1'b0; D = 32'hB4B3B2B1;
        push("ge_low", 32'hA4A3A2A1, 4'h0, 4'h2, 8'hFF, 1'b0);
        tick();
        // every channel now in HOLD with one cycle left
        PRE = 1'b1;
        #1;
        push("pre_in_hold", 32'hFFFFFFFF, 4'h0, 4'h0, 8'hFF, 1'b0);
        compare();
        GE = 1'b1; G = 4'b1111; D = 32'hC4C3C2C1; g_b = 1'b1; d_b = 8'hCC;
        push("pre_held", 32'hFFFFFFFF, 4'h0, 4'h0, 8'hFF, 1'b0);
        tick();
        PRE = 1'b0; G = 4'b0011; D = 32'hD4D3D2D1; g_b = 1'b1; d_b = 8'h10;
        push("after_pre", 32'hFFFFD2D1, 4'h3, 4'h0, 8'h10, 1'b1);
        tick();
        g_b = 1'b0; d_b = 8'h20;
        push("h0_close", 32'hFFFFD2D1, 4'h3, 4'h0, 8'h10, 1'b0);
        tick();
        g_b = 1'b1; d_b = 8'h30;
        push("h0_open", 32'hFFFFD2D1, 4'h3, 4'h0, 8'h30, 1'b1);
        tick();
        g_b = 1'b0; d_b = 8'h40;
        push("h0_close2", 32'hFFFFD2D1, 4'h3, 4'h0, 8'h30, 1'b0);
        tick();
        g_b = 1'b1; d_b = 8'h50;
        push("h0_open2", 32'hFFFFD2D1, 4'h3, 4'h0, 8'h50, 1'b1);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
